// File: rtl/demux_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
//
// Shared definitions for the demux_1_n_stream family:
//   - clog2()       : ceiling log2 used to size the channel select
//   - DROP_CNT_W    : width of the saturating dropped-word counter
//   - chan_state_t  : per-channel holding register state (EMPTY / FULL)
// -----------------------------------------------------------------------------
package demux_pkg;

    localparam int DROP_CNT_W = 16;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_t;

    // Ceiling log2, usable in parameter expressions. clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage : demux_pkg

// File: rtl/demux_chan_reg.sv
// -----------------------------------------------------------------------------
// demux_chan_reg
//
// One-entry holding register for a single demux output channel. A load fills
// the register (or replaces the word being drained in the same cycle); a drain
// without a load empties it. The data register is cleared whenever the channel
// is empty so the consumer never sees stale data.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   load       in   write load_data into the register this cycle
//   load_data  in   W-bit word to store
//   drain      in   consumer takes the held word this cycle
//   valid      out  register holds a word (state FULL)
//   data       out  held word, zero while EMPTY
// -----------------------------------------------------------------------------
module demux_chan_reg
    import demux_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         drain,
    output logic         valid,
    output logic [W-1:0] data
);

    chan_state_t  state_q, state_d;
    logic [W-1:0] data_q, data_d;

    // Next-state logic. Load wins over drain so a simultaneous drain+load
    // keeps the channel FULL with the new word (full-throughput path).
    always_comb begin
        // NOTE: every signal driven here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_d = state_q;
        data_d  = data_q;
        if (load) begin
            state_d = FULL;
            data_d  = load_data;
        end else if (drain) begin
            state_d = EMPTY;
            data_d  = '0;
        end
    end

    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values; blocking ones would make results depend on order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the data register is reset too, not just the state,
            // because an empty channel must present zero data.
            state_q <= EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign valid = (state_q == FULL);
    assign data  = data_q;

endmodule : demux_chan_reg

// File: rtl/demux_1_n_stream.sv
// -----------------------------------------------------------------------------
// demux_1_n_stream
//
// Registered 1-to-N_CH stream demultiplexer. Each accepted input word is
// routed to the channel named by in_sel and held in that channel's one-entry
// register until its consumer takes it. Empty channels drive zero data.
// Selects at or beyond N_CH (only possible when N_CH is not a power of two)
// are accepted, discarded and counted in drop_cnt.
//
// Optional feature (macro DEMUX_SEL_CHECK_EN):
//   defined     : err pulses for one cycle, the cycle after an out-of-range
//                 word is accepted (registered output)
//   not defined : err is tied to 0
//
// Parameters:
//   N_CH   number of output channels (>= 2)
//   W      data width per channel
//   SEL_W  select width, derived from N_CH (do not override)
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   in_valid   in   producer has a word
//   in_ready   out  word is accepted this cycle when in_valid=1
//   in_sel     in   destination channel index
//   in_data    in   input word
//   out_valid  out  per-channel word present
//   out_ready  in   per-channel consumer ready
//   out_data   out  packed channel data, channel i = [i*W +: W]
//   err        out  out-of-range select pulse
//   drop_cnt   out  saturating count of discarded words
// -----------------------------------------------------------------------------
module demux_1_n_stream
    import demux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int W     = 4,
    parameter int SEL_W = clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic [W-1:0]          in_data,
    output logic [N_CH-1:0]       out_valid,
    input  logic [N_CH-1:0]       out_ready,
    output logic [N_CH*W-1:0]     out_data,
    output logic                  err,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    logic                  sel_in_range;
    logic                  accept;
    logic [N_CH-1:0]       chan_valid;
    logic [N_CH-1:0]       load;
    logic [N_CH-1:0]       drain;
    logic [DROP_CNT_W-1:0] drop_q;

    // Range check only exists when the select can encode more than N_CH values;
    // for power-of-two channel counts every select is valid.
    generate
        if ((1 << SEL_W) == N_CH) begin : g_sel_full
            assign sel_in_range = 1'b1;
        end else begin : g_sel_partial
            localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);
            assign sel_in_range = (in_sel <= LAST_CH);
        end
    endgenerate

    // A channel can take a word if it is empty or is being drained this cycle.
    // Out-of-range words are always taken (and dropped). out_ready reaches
    // in_ready combinationally so a drained channel can reload in the same cycle.
    always_comb begin
        in_ready = 1'b1;
        if (sel_in_range) begin
            in_ready = ~chan_valid[in_sel] | out_ready[in_sel];
        end
    end

    assign accept = in_valid & in_ready;

    // One-hot load decode: at most one channel loads per cycle.
    always_comb begin
        load = '0;
        if (accept && sel_in_range) begin
            load[in_sel] = 1'b1;
        end
    end

    // Drains are independent per channel and may coincide with a load elsewhere.
    assign drain = chan_valid & out_ready;

    generate
        for (genvar g = 0; g < N_CH; g++) begin : g_chan
            demux_chan_reg #(
                .W (W)
            ) u_chan (
                .clk       (clk),
                .rst       (rst),
                .load      (load[g]),
                .load_data (in_data),
                .drain     (drain[g]),
                .valid     (chan_valid[g]),
                .data      (out_data[g*W +: W])
            );
        end
    endgenerate

    assign out_valid = chan_valid;

    // Dropped-word counter, saturating at all ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= '0;
        end else if (accept && !sel_in_range && (drop_q != '1)) begin
            drop_q <= drop_q + 1'b1;
        end
    end

    assign drop_cnt = drop_q;

`ifdef DEMUX_SEL_CHECK_EN
    logic err_q;

    // Registered so err appears in the cycle after the offending accept and
    // lasts exactly one cycle per dropped word.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= accept & ~sel_in_range;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule : demux_1_n_stream
